// File: rtl/multi_button_debounce_if.sv
// ============================================================================
// Module   : multi_button_debounce_if
// Brief    : Raw button pins in, debounced level and event pulses out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multi_button_debounce_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_short;
  logic [N_BTN-1:0] btn_long;
  logic [N_BTN-1:0] btn_repeat;

  // master = board/consumer side, slave = the debouncer
  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_short, btn_long, btn_repeat
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_short, btn_long, btn_repeat
  );
endinterface

`default_nettype wire

// File: rtl/multi_button_debounce.sv
// ============================================================================
// Module   : multi_button_debounce
// Brief    : N independent channels of sync + debounce + press/release/short/
//            long/auto-repeat single-cycle event generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_button_debounce #(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = 2_000_000,
  parameter int               LONG_CYCLES     = 100_000_000,
  parameter int               REPEAT_CYCLES   = 20_000_000,
  parameter bit               REPEAT_EN       = 1'b1,
  parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = '0
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  multi_button_debounce_if.slave        bus
);

  localparam int c_DEB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int c_HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int c_HOLD_W   = $clog2(c_HOLD_MAX + 1);

  localparam logic [c_DEB_W-1:0]  c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_LONG     = c_HOLD_W'(LONG_CYCLES);
  localparam logic [c_HOLD_W-1:0] c_REP_LAST = c_HOLD_W'(REPEAT_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic                r_s0;
    logic                r_s1;
    logic                r_level;
    logic [c_DEB_W-1:0]  r_db_cnt;
    logic                w_settle;
    logic                w_rise;
    logic                w_fall;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;

    logic w_press_nxt, w_release_nxt, w_short_nxt, w_long_nxt, w_repeat_nxt;
    logic r_press, r_release, r_short, r_long, r_repeat;

    // Sync flops reset to the post-polarity "released" value (0).
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s0     <= 1'b0;
        r_s1     <= 1'b0;
        r_level  <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        r_s0 <= bus.btn_in[i] ^ ACTIVE_LOW_MASK[i];
        r_s1 <= r_s0;
        if (r_s1 == r_level) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == c_DEB_LAST) begin
          r_level  <= r_s1;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
    end

    // Level is about to change this edge; lets the event pulses line up with it.
    assign w_settle = (r_s1 != r_level) && (r_db_cnt == c_DEB_LAST);
    assign w_rise   = w_settle & r_s1;
    assign w_fall   = w_settle & ~r_s1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= ST_IDLE;
        r_hold    <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_short   <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_hold    <= w_hold_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
        r_short   <= w_short_nxt;
        r_long    <= w_long_nxt;
        r_repeat  <= w_repeat_nxt;
      end
    end

    // A falling level always wins over a long/repeat threshold in the same cycle.
    always_comb begin
      w_state_nxt   = r_state;
      w_hold_nxt    = r_hold;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_short_nxt   = 1'b0;
      w_long_nxt    = 1'b0;
      w_repeat_nxt  = 1'b0;
      case (r_state)
        ST_IDLE: begin
          w_hold_nxt = '0;
          if (w_rise) begin
            w_state_nxt = ST_PRESSED;
            w_hold_nxt  = c_HOLD_ONE;
            w_press_nxt = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (w_fall) begin
            w_state_nxt   = ST_IDLE;
            w_hold_nxt    = '0;
            w_release_nxt = 1'b1;
            w_short_nxt   = 1'b1;
          end else if (r_hold == c_LONG) begin
            w_state_nxt = ST_LONG;
            w_hold_nxt  = '0;
            w_long_nxt  = 1'b1;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
        ST_LONG: begin
          if (w_fall) begin
            w_state_nxt   = ST_IDLE;
            w_hold_nxt    = '0;
            w_release_nxt = 1'b1;
          end else if (!REPEAT_EN) begin
            w_hold_nxt = '0;
          end else if (r_hold == c_REP_LAST) begin
            w_hold_nxt   = '0;
            w_repeat_nxt = 1'b1;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
        end
      endcase
    end

    assign bus.btn_level[i]   = r_level;
    assign bus.btn_press[i]   = r_press;
    assign bus.btn_release[i] = r_release;
    assign bus.btn_short[i]   = r_short;
    assign bus.btn_long[i]    = r_long;
    assign bus.btn_repeat[i]  = r_repeat;
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_button_debounce.sv
// ============================================================================
// Module   : tb_multi_button_debounce
// Brief    : Scoreboard bench for multi_button_debounce (two configurations).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_button_debounce;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] shrt;
    logic [1:0] lng;
    logic [1:0] rep;
    logic [1:0] lvl;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  bit   done = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  ev_t  qa[$];
  ev_t  qb[$];

  multi_button_debounce_if #(.N_BTN(2)) bus_a ();
  multi_button_debounce_if #(.N_BTN(2)) bus_b ();

  // A: ch1 active-low, auto-repeat on.  B: mirrors A's ch0, auto-repeat off.
  multi_button_debounce #(
    .N_BTN(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8),
    .REPEAT_EN(1'b1), .ACTIVE_LOW_MASK(2'b10)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  multi_button_debounce #(
    .N_BTN(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8),
    .REPEAT_EN(1'b0), .ACTIVE_LOW_MASK(2'b00)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.btn_in = {1'b0, bus_a.btn_in[0]};

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, cycle %0d, required done", cyc);
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk(int c, logic [1:0] p, logic [1:0] r, logic [1:0] s,
                             logic [1:0] l, logic [1:0] rp, logic [1:0] lv);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.shrt = s; e.lng = l; e.rep = rp; e.lvl = lv;
    return e;
  endfunction

  // Monitor side: pops one expectation whenever a DUT shows any pulse.
  task automatic check_dut(input int d, input ev_t act);
    ev_t exp;
    int  qn;
    qn = (d == 0) ? qa.size() : qb.size();
    if ((act.press | act.rel | act.shrt | act.lng | act.rep) != 2'b00) begin
      n_tests++;
      if (qn == 0) begin
        n_fail++;
        $display("FAIL dut%0d unexpected_pulse cyc=%0d press=%b rel=%b short=%b long=%b rep=%b, required no pulse",
                 d, act.cyc, act.press, act.rel, act.shrt, act.lng, act.rep);
      end else begin
        exp = (d == 0) ? qa.pop_front() : qb.pop_front();
        if (act.cyc != exp.cyc || act.press != exp.press || act.rel != exp.rel ||
            act.shrt != exp.shrt || act.lng != exp.lng || act.rep != exp.rep ||
            act.lvl != exp.lvl) begin
          n_fail++;
          $display("FAIL dut%0d event got cyc=%0d p=%b r=%b s=%b l=%b rp=%b lvl=%b, required cyc=%0d p=%b r=%b s=%b l=%b rp=%b lvl=%b",
                   d, act.cyc, act.press, act.rel, act.shrt, act.lng, act.rep, act.lvl,
                   exp.cyc, exp.press, exp.rel, exp.shrt, exp.lng, exp.rep, exp.lvl);
        end
      end
    end else if (qn != 0) begin
      exp = (d == 0) ? qa[0] : qb[0];
      if (exp.cyc < act.cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut%0d missed_event not observed by cyc=%0d, required p=%b r=%b s=%b l=%b rp=%b at cyc=%0d",
                 d, act.cyc, exp.press, exp.rel, exp.shrt, exp.lng, exp.rep, exp.cyc);
        if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      end
    end
  endtask

  initial begin
    ev_t aa, bb;
    logic [11:0] outs_a, outs_b;
    forever begin
      @(negedge clk);
      if (done) break;
      outs_a = {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release,
                bus_a.btn_short, bus_a.btn_long, bus_a.btn_repeat};
      outs_b = {bus_b.btn_level, bus_b.btn_press, bus_b.btn_release,
                bus_b.btn_short, bus_b.btn_long, bus_b.btn_repeat};
      if (rst) begin
        n_tests++;
        if (outs_a != 12'h000 || outs_b != 12'h000) begin
          n_fail++;
          $display("FAIL reset_outputs cyc=%0d a=%h b=%h, required 000 000", cyc, outs_a, outs_b);
        end
      end else begin
        aa = mk(cyc, bus_a.btn_press, bus_a.btn_release, bus_a.btn_short,
                bus_a.btn_long, bus_a.btn_repeat, bus_a.btn_level);
        bb = mk(cyc, bus_b.btn_press, bus_b.btn_release, bus_b.btn_short,
                bus_b.btn_long, bus_b.btn_repeat, bus_b.btn_level);
        check_dut(0, aa);
        check_dut(1, bb);
      end
    end
    n_tests++;
    if (qa.size() != 0) begin
      n_fail++;
      $display("FAIL dut0 leftover_events got %0d pending, required 0", qa.size());
    end
    n_tests++;
    if (qb.size() != 0) begin
      n_fail++;
      $display("FAIL dut1 leftover_events got %0d pending, required 0", qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push the same ch0 expectation into both scoreboards.
  task automatic push_both(input ev_t e);
    qa.push_back(e);
    qb.push_back(e);
  endtask

  initial begin
    int p;
    int r;
    bus_a.btn_in = 2'b10;
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);

    // clean press, then short click released 10 cycles after press
    bus_a.btn_in[0] = 1'b1;
    p = cyc + 6;
    push_both(mk(p, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    tick(16);
    bus_a.btn_in[0] = 1'b0;
    push_both(mk(cyc + 6, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    tick(12);

    // bounce: 2-cycle runs never qualify; final step to 1 is accepted
    for (int k = 0; k < 10; k++) begin
      bus_a.btn_in[0] = ~bus_a.btn_in[0];
      tick(2);
    end
    bus_a.btn_in[0] = 1'b1;
    p = cyc + 6;
    push_both(mk(p, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    tick(6);

    // long press with repeats, then release (no short)
    push_both(mk(p + 20, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01));
    qa.push_back(mk(p + 28, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    qa.push_back(mk(p + 36, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    qa.push_back(mk(p + 44, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    tick(45);
    bus_a.btn_in[0] = 1'b0;
    push_both(mk(p + 51, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    tick(12);

    // release lands exactly on the long threshold: release+short only
    bus_a.btn_in[0] = 1'b1;
    p = cyc + 6;
    push_both(mk(p, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    tick(20);
    bus_a.btn_in[0] = 1'b0;
    push_both(mk(p + 20, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    tick(12);

    // active-low channel 1 on DUT A
    bus_a.btn_in[1] = 1'b0;
    qa.push_back(mk(cyc + 6, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));
    tick(10);
    bus_a.btn_in[1] = 1'b1;
    qa.push_back(mk(cyc + 6, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
    tick(12);

    // reset while in LONG, pin kept pressed through reset release
    bus_a.btn_in[0] = 1'b1;
    p = cyc + 6;
    push_both(mk(p, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    push_both(mk(p + 20, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01));
    qa.push_back(mk(p + 28, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    tick(36);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    r = cyc;
    push_both(mk(r + 6, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    push_both(mk(r + 26, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01));
    qa.push_back(mk(r + 34, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    tick(36);
    // release at r+42 coincides with the next repeat and suppresses it
    bus_a.btn_in[0] = 1'b0;
    push_both(mk(r + 42, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    tick(15);
    done = 1'b1;
  end

endmodule

`default_nettype wire

// File: doc/multi_button_debounce.md
Name: multi_button_debounce

Overview:
- Parametrised N-channel successor to the single-button debouncer.
- Each channel provides:
  - a two-flop synchroniser, with optional polarity inversion;
  - a stable-time debouncer;
  - single-cycle event pulses: press, release, short-click, long-press and auto-repeat.
- Sits between the board push-buttons and the calculator's menu/input FSMs. Those FSMs consume the pulses directly, with no further edge detection.

Parameters:
- N_BTN, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 2_000_000, consecutive stable cycles required to accept a level change (20 ms @ 100 MHz); must be ≥2.
- LONG_CYCLES, 100_000_000, held cycles before btn_long fires (1 s); must be > DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 20_000_000, period of btn_repeat pulses after long-press (200 ms); must be ≥2.
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = no btn_repeat pulses.
- ACTIVE_LOW_MASK, {N_BTN{1'b0}}, bit i = 1 means btn_in[i] is pressed when 0.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- btn_in  in  N_BTN  raw asynchronous button pins.
- btn_level  out  N_BTN  debounced level, 1 = pressed (after polarity).
- btn_press  out  N_BTN  1-cycle pulse on debounced 0→1.
- btn_release  out  N_BTN  1-cycle pulse on debounced 1→0.
- btn_short  out  N_BTN  1-cycle pulse on release when the long-press threshold was never reached.
- btn_long  out  N_BTN  1-cycle pulse when held LONG_CYCLES.
- btn_repeat  out  N_BTN  1-cycle pulses every REPEAT_CYCLES after btn_long while still held.

Behaviour:
Reset and general
- Clock: one clock, clk; reset: rst, asynchronous, active-high.
- All registers clear on rst: sync flops, counters, state = IDLE, and every output bit 0.
- Polarity: the sync flops hold the "released" value, so no spurious press after reset for active-low inputs.
- Channels are fully independent; no cross-channel interaction.
- All outputs are registered.

Synchroniser
- s0 <= btn_in ^ ACTIVE_LOW_MASK; s1 <= s0.
- s1 is the debouncer input.

Debouncer, per channel
- Counter width: $clog2(DEBOUNCE_CYCLES).
- If s1 == btn_level: counter <= 0.
- Otherwise counter increments.
- When counter == DEBOUNCE_CYCLES-1 with s1 still differing: btn_level <= s1 and counter <= 0.
- Any single-cycle return to the old value restarts the count from 0.
- Latency from a clean pin step to the btn_level edge: 2 + DEBOUNCE_CYCLES cycles.

Event FSM, per channel (states IDLE, PRESSED, LONG)
- Hold counter width: $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1).
- IDLE, and btn_level rises:
  - go to PRESSED, hold counter <= 1;
  - btn_press = 1 in the same cycle btn_level first reads 1.
- PRESSED:
  - Counter increments each cycle.
  - When it reaches LONG_CYCLES: btn_long pulses, go to LONG, counter <= 0.
  - So btn_long fires exactly LONG_CYCLES cycles after btn_press.
- PRESSED, and level falls: btn_release and btn_short pulse together; go to IDLE.
- LONG, with REPEAT_EN = 1:
  - Counter increments.
  - At REPEAT_CYCLES: btn_repeat pulses and counter <= 0.
  - So the first repeat comes REPEAT_CYCLES after btn_long.
- LONG, with REPEAT_EN = 0: counter held at 0 and btn_repeat stays 0.
- LONG, and level falls: btn_release pulses, btn_short stays 0; go to IDLE.

Simultaneous events
- Release takes priority over a long/repeat pulse due in the same cycle; the long/repeat pulse is suppressed.
- btn_press and btn_release can never coincide, because btn_level is held ≥DEBOUNCE_CYCLES between edges.
- Counters never wrap: the hold counter is cleared at each threshold.

Reset mid-operation
- Immediate return to IDLE with all outputs 0.
- A button held through reset release produces a fresh btn_press after 2 + DEBOUNCE_CYCLES cycles.

Test Plan:
Simulation parameters: N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
1. Clean press ch0: btn_in[0] 0→1 at cycle 10, held → btn_level[0] and btn_press[0] high at cycle 16 (2 + 4); btn_press is 1 cycle wide; ch1 outputs stay 0.
2. Bounce: toggle btn_in[0] every 2 cycles for 20 cycles, then hold 1 → no pulses during bounce; btn_press exactly 6 cycles after the last toggle.
3. Short click: hold 10 cycles after btn_press, then release cleanly → btn_release and btn_short pulse together 6 cycles after the pin falls; no btn_long.
4. Long + repeat: hold 45 cycles past btn_press → btn_long at +20; btn_repeat at +28, +36, +44; release → btn_release only, btn_short = 0. Rerun with REPEAT_EN=0 → no btn_repeat.
5. Active-low: ACTIVE_LOW_MASK=2'b10, btn_in[1]=1 during and after reset → no pulses; drive 0 → btn_press[1] after 6 cycles.
6. Reset mid-hold: assert rst in LONG state → all outputs 0 within the same cycle (asynchronous); deassert with the pin still pressed → btn_press after 6 cycles; btn_long 20 cycles later.
